// File: rtl/cache_assoc_param.sv
// Parameterised SETS x WAYS write-back, write-allocate cache with one data word per line.
// Replacement is true LRU: each line keeps an age, and the ages within a set always form a permutation.
// Ports:
//   clock, reset (async, active low)
//   CPU side:    address, write_data, read, write, flush -> read_data, done, hit, busy
//   Memory side: mem_req, mem_we, mem_addr, mem_wdata <- mem_ready, mem_rdata
// All outputs are registered.
module cache_assoc_param #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SETS   = 2,
    parameter int unsigned WAYS   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read,
    input  logic              write,
    input  logic              flush,
    output logic [DATA_W-1:0] read_data,
    output logic              done,
    output logic              hit,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W;
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned AGE_W  = WAY_W;
    localparam int unsigned LINE_W = IDX_W + WAY_W;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(SETS * WAYS - 1);
    localparam logic [AGE_W-1:0]  OLDEST    = AGE_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                store_q, store_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic                valid_q [SETS][WAYS];
    logic                valid_d [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic                dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]    tag_d   [SETS][WAYS];
    logic [DATA_W-1:0]   data_q  [SETS][WAYS];
    logic [DATA_W-1:0]   data_d  [SETS][WAYS];
    logic [AGE_W-1:0]    age_q   [SETS][WAYS];
    logic [AGE_W-1:0]    age_d   [SETS][WAYS];

    logic                done_q, done_d;
    logic                hit_q, hit_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    f_set;
    logic [WAY_W-1:0]    f_way;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_any;
    logic [WAY_W-1:0]    victim;
    logic                touch_en;
    logic [WAY_W-1:0]    touch_way;
    logic [AGE_W-1:0]    old_age;
    logic                adv;

    assign idx   = addr_q[IDX_W-1:0];
    assign tag   = addr_q[ADDR_W-1:IDX_W];
    assign f_set = line_q[LINE_W-1:WAY_W];
    assign f_way = line_q[WAY_W-1:0];

    // Next-state, array update and registered-output computation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        store_d     = store_q;
        way_d       = way_q;
        line_d      = line_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        age_d       = age_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        touch_en    = 1'b0;
        touch_way   = way_q;
        old_age     = '0;
        adv         = 1'b0;

        // Tag match in the addressed set
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end

        // Victim: lowest invalid way (descending scan so the lowest wins), else the oldest
        inv_any = 1'b0;
        victim  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                victim  = WAY_W'(w);
            end
        end
        if (!inv_any) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == OLDEST) victim = WAY_W'(w);
            end
        end

        case (state_q)
            IDLE: begin
                if (write || read) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    store_d = write;
                    state_d = LOOKUP;
                end else if (flush) begin
                    line_d  = '0;
                    state_d = FLUSH;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    touch_en  = 1'b1;
                    touch_way = hit_way;
                    done_d    = 1'b1;
                    hit_d     = 1'b1;
                    if (store_q) begin
                        data_d[idx][hit_way]  = wdata_q;
                        dirty_d[idx][hit_way] = 1'b1;
                        rdata_d               = wdata_q;
                    end else begin
                        rdata_d = data_q[idx][hit_way];
                    end
                    state_d = IDLE;
                end else begin
                    way_d     = victim;
                    mem_req_d = 1'b1;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx][victim], idx};
                        mem_wdata_d = data_q[idx][victim];
                        state_d     = WRITEBACK;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        state_d    = FILL;
                    end
                end
            end
            WRITEBACK: begin
                // mem_req stays high straight into the fill request
                if (mem_ready) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_ready) begin
                    valid_d[idx][way_q] = 1'b1;
                    tag_d[idx][way_q]   = tag;
                    if (store_q) begin
                        data_d[idx][way_q]  = wdata_q;
                        dirty_d[idx][way_q] = 1'b1;
                        rdata_d             = wdata_q;
                    end else begin
                        data_d[idx][way_q]  = mem_rdata;
                        dirty_d[idx][way_q] = 1'b0;
                        rdata_d             = mem_rdata;
                    end
                    touch_en  = 1'b1;
                    touch_way = way_q;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            FLUSH: begin
                if (mem_req_q) begin
                    if (mem_ready) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        adv       = 1'b1;
                    end
                end else if (valid_q[f_set][f_way] && dirty_q[f_set][f_way]) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[f_set][f_way], f_set};
                    mem_wdata_d = data_q[f_set][f_way];
                end else begin
                    adv = 1'b1;
                end
                if (adv) begin
                    if (line_q == LAST_LINE) begin
                        for (int s = 0; s < SETS; s++) begin
                            for (int w = 0; w < WAYS; w++) begin
                                valid_d[s][w] = 1'b0;
                                dirty_d[s][w] = 1'b0;
                            end
                        end
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        line_d = line_q + LINE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // LRU: touched way becomes youngest, ways younger than its old age shift up by one
        if (touch_en) begin
            old_age = age_q[idx][touch_way];
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] < old_age) age_d[idx][w] = age_q[idx][w] + AGE_W'(1);
            end
            age_d[idx][touch_way] = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            way_q       <= '0;
            line_q      <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            store_q     <= store_d;
            way_q       <= way_d;
            line_q      <= line_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            age_q       <= age_d;
        end
    end

    assign read_data = rdata_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_assoc_param.sv
// Bench for cache_assoc_param (default parameters): table of CPU requests with
// hand-derived responses, memory model mem[a]=a answering 3 cycles after mem_req,
// and ordered queues of expected CPU responses and memory transactions.
module tb_cache_assoc_param;
    localparam int OP_R  = 0;
    localparam int OP_W  = 1;
    localparam int OP_RW = 2;
    localparam int OP_F  = 3;
    localparam int NVEC  = 18;

    logic        clock;
    logic        reset;
    logic [5:0]  address;
    logic [15:0] write_data;
    logic        read, write, flush;
    logic [15:0] read_data;
    logic        done, hit, busy;
    logic        mem_req, mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    logic [15:0] mem [64];
    int          mem_cnt;
    int          checks;
    int          failures;

    typedef struct {
        logic        hit;
        logic [15:0] data;
        logic        chk;
    } resp_t;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] data;
    } mtx_t;

    typedef struct {
        int          op;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic        exp_hit;
        logic [15:0] exp_data;
        int          n_wb;
        logic [5:0]  wb0_a;
        logic [15:0] wb0_d;
        logic [5:0]  wb1_a;
        logic [15:0] wb1_d;
    } vec_t;

    resp_t exp_q[$];
    mtx_t  mexp_q[$];
    vec_t  vecs[NVEC];

    cache_assoc_param dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .read       (read),
        .write      (write),
        .flush      (flush),
        .read_data  (read_data),
        .done       (done),
        .hit        (hit),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [5:0] a, input logic [15:0] wd,
                                input logic h, input logic [15:0] d, input int nwb,
                                input logic [5:0] a0, input logic [15:0] d0,
                                input logic [5:0] a1, input logic [15:0] d1);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = wd; v.exp_hit = h; v.exp_data = d;
        v.n_wb = nwb; v.wb0_a = a0; v.wb0_d = d0; v.wb1_a = a1; v.wb1_d = d1;
        return v;
    endfunction

    // Memory responder: ready 3 cycles into a request; checks each transaction in order
    always @(negedge clock) begin
        mtx_t m;
        if (!reset) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_req) begin
            mem_cnt++;
            if (mem_cnt == 3) begin
                mem_ready = 1'b1;
                if (mexp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem: got we=%0b addr=%0h, required no transaction", mem_we, mem_addr);
                end else begin
                    m = mexp_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                    if (m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.data));
                end
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
        end
        if (reset && !busy) chk("mem_req_idle", 32'(mem_req), 32'd0);
    end

    // Response scoreboard
    always @(negedge clock) begin
        resp_t r;
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 data=%0h, required no done", read_data);
            end else begin
                r = exp_q.pop_front();
                chk("resp_hit", 32'(hit), 32'(r.hit));
                if (r.chk) chk("resp_data", 32'(read_data), 32'(r.data));
            end
        end
    end

    task automatic push_exp(input vec_t v);
        resp_t r;
        mtx_t  m;
        r.hit = v.exp_hit; r.data = v.exp_data; r.chk = (v.op != OP_F);
        exp_q.push_back(r);
        if (v.n_wb > 0) begin m.we = 1'b1; m.addr = v.wb0_a; m.data = v.wb0_d; mexp_q.push_back(m); end
        if (v.n_wb > 1) begin m.we = 1'b1; m.addr = v.wb1_a; m.data = v.wb1_d; mexp_q.push_back(m); end
        if (v.op != OP_F && !v.exp_hit) begin
            m.we = 1'b0; m.addr = v.addr; m.data = '0; mexp_q.push_back(m);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int edges;
        int memc;
        push_exp(v);
        @(negedge clock);
        address    = v.addr;
        write_data = v.wdata;
        read       = (v.op == OP_R) || (v.op == OP_RW);
        write      = (v.op == OP_W) || (v.op == OP_RW);
        flush      = (v.op == OP_F);
        edges = 0;
        memc  = 0;
        do begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            read = 1'b0; write = 1'b0; flush = 1'b0;
            if (mem_req) memc++;
        end while (!done && edges < 200);
        chk("done_seen", 32'(done), 32'd1);
        if (v.exp_hit) begin
            chk("hit_latency", 32'(edges), 32'd2);
            chk("hit_no_mem", 32'(memc), 32'd0);
        end
        @(negedge clock);
        chk("done_pulse", 32'(done), 32'd0);
        if (v.op != OP_F) chk("rdata_hold", 32'(read_data), 32'(v.exp_data));
    endtask

    initial begin
        int n;
        for (int a = 0; a < 64; a++) mem[a] = 16'(a);
        checks = 0; failures = 0; mem_cnt = 0;
        mem_ready = 1'b0;
        reset = 1'b0; read = 1'b0; write = 1'b0; flush = 1'b0;
        address = '0; write_data = '0;

        repeat (3) @(negedge clock);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_read_data", 32'(read_data), 32'd0);
        reset = 1'b1;

        vecs[0]  = mk(OP_R,  6'd1,  16'h0,    1'b0, 16'd1,    0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[1]  = mk(OP_R,  6'd1,  16'h0,    1'b1, 16'd1,    0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[2]  = mk(OP_R,  6'd20, 16'h0,    1'b0, 16'd20,   0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[3]  = mk(OP_R,  6'd22, 16'h0,    1'b0, 16'd22,   0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[4]  = mk(OP_R,  6'd20, 16'h0,    1'b1, 16'd20,   0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[5]  = mk(OP_R,  6'd4,  16'h0,    1'b0, 16'd4,    0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[6]  = mk(OP_R,  6'd20, 16'h0,    1'b1, 16'd20,   0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[7]  = mk(OP_R,  6'd22, 16'h0,    1'b0, 16'd22,   0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[8]  = mk(OP_W,  6'd2,  16'hABCD, 1'b0, 16'hABCD, 0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[9]  = mk(OP_R,  6'd4,  16'h0,    1'b0, 16'd4,    0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[10] = mk(OP_R,  6'd6,  16'h0,    1'b0, 16'd6,    1, 6'd2, 16'hABCD, 6'd0, 16'h0);
        vecs[11] = mk(OP_R,  6'd2,  16'h0,    1'b0, 16'hABCD, 0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[12] = mk(OP_W,  6'd2,  16'h1111, 1'b1, 16'h1111, 0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[13] = mk(OP_W,  6'd3,  16'h2222, 1'b0, 16'h2222, 0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[14] = mk(OP_F,  6'd0,  16'h0,    1'b0, 16'h0,    2, 6'd2, 16'h1111, 6'd3, 16'h2222);
        vecs[15] = mk(OP_R,  6'd2,  16'h0,    1'b0, 16'h1111, 0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[16] = mk(OP_RW, 6'd5,  16'h5555, 1'b0, 16'h5555, 0, 6'd0, 16'h0, 6'd0, 16'h0);
        vecs[17] = mk(OP_R,  6'd5,  16'h0,    1'b1, 16'h5555, 0, 6'd0, 16'h0, 6'd0, 16'h0);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Reset while a fill is outstanding: abort, no done, cache emptied
        @(negedge clock);
        address = 6'd9; read = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("abort_fill_req", 32'(mem_req), 32'd1);
        chk("abort_fill_we", 32'(mem_we), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_vec(mk(OP_R, 6'd9, 16'h0, 1'b0, 16'd9, 0, 6'd0, 16'h0, 6'd0, 16'h0));

        // A read pulse while busy is dropped: one done and one fill only
        push_exp(mk(OP_R, 6'd7, 16'h0, 1'b0, 16'd7, 0, 6'd0, 16'h0, 6'd0, 16'h0));
        @(negedge clock);
        address = 6'd7; read = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        @(negedge clock);
        chk("busy_when_pulsed", 32'(busy), 32'd1);
        address = 6'd11; read = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("busy_req_done", 32'(done), 32'd1);
        repeat (20) @(negedge clock);
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("mem_queue_empty", 32'(mexp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_assoc_param.md
CACHE_ASSOC_PARAM -- requirements
Module: cache_assoc_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, byte-less word address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter SETS, default 2, number of sets; power of two, >=2.
REQ-004 SHALL have parameter WAYS, default 2, associativity; power of two, >=2.
REQ-005 SHALL have a port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have a port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have a port `address`, input, ADDR_W bits: word address; index = low log2(SETS) bits, tag = remaining upper bits.
REQ-008 SHALL have a port `write_data`, input, DATA_W bits: store data.
REQ-009 SHALL have a port `read`, input, 1 bit: load request.
REQ-010 SHALL have a port `write`, input, 1 bit: store request.
REQ-011 SHALL have a port `flush`, input, 1 bit: write back all dirty lines, then invalidate all lines.
REQ-012 SHALL have a port `read_data`, output, DATA_W bits: load result, valid while done=1.
REQ-013 SHALL have a port `done`, output, 1 bit: one-cycle completion pulse for a request or a flush.
REQ-014 SHALL have a port `hit`, output, 1 bit: qualified by done; 1 = completed without a memory access.
REQ-015 SHALL have a port `busy`, output, 1 bit: 1 in every state except IDLE.
REQ-016 SHALL have memory-side ports `mem_req` (out, 1), `mem_we` (out, 1), `mem_addr` (out, ADDR_W), `mem_wdata` (out, DATA_W), `mem_ready` (in, 1) and `mem_rdata` (in, DATA_W).

Function
REQ-017 SHALL implement a write-back, write-allocate SETS x WAYS cache; each line holds valid, dirty, tag, one data word and a log2(WAYS)-bit age.
REQ-018 SHALL use FSM states IDLE, LOOKUP, WRITEBACK, FILL, RESPOND, FLUSH.
REQ-019 In IDLE, on a clock edge with write=1, SHALL latch address/write_data as a store, go to LOOKUP; write wins if read=1 simultaneously.
REQ-020 In IDLE, on a clock edge with read=1 and write=0, SHALL latch the request as a load and go to LOOKUP.
REQ-021 In IDLE, flush SHALL be accepted only when read=0 and write=0; on acceptance SHALL go to FLUSH.
REQ-022 SHALL ignore read, write and flush while busy=1; no queuing.
REQ-023 LOOKUP hit SHALL assert done=1 and hit=1 for exactly that cycle (load latency 2 edges from acceptance), update LRU, return to IDLE.
REQ-024 On a store hit, SHALL write data and set dirty.
REQ-025 LOOKUP miss SHALL select a victim: the lowest-index invalid way, else the way with age = WAYS-1.
REQ-026 On a miss with a dirty victim, SHALL go to WRITEBACK.
REQ-027 On a miss with a clean victim, SHALL go to FILL.
REQ-028 WRITEBACK SHALL drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data, held stable until a clock edge with mem_ready=1, then go to FILL.
REQ-029 FILL SHALL drive mem_req=1, mem_we=0, mem_addr=latched address, held until mem_ready=1.
REQ-030 On that edge FILL SHALL install mem_rdata, set valid=1 and dirty=0.
REQ-031 A store completing FILL SHALL then overwrite the installed word with write_data and set dirty=1.
REQ-032 FILL SHALL then go to RESPOND.
REQ-033 RESPOND SHALL assert done=1 and hit=0 for one cycle, with read_data = line data, then go to IDLE.
REQ-034 On any access (hit or install), the accessed way's age SHALL become 0.
REQ-035 On any access, ways in the set whose age was below the accessed way's old age SHALL increment; all others SHALL hold.
REQ-036 Ages within a set SHALL always be a permutation of 0..WAYS-1.
REQ-037 FLUSH SHALL scan lines in order set 0..SETS-1, way 0..WAYS-1.
REQ-038 For each valid dirty line, FLUSH SHALL perform a write-back with the WRITEBACK handshake.
REQ-039 After the last line, FLUSH SHALL clear all valid/dirty bits, pulse done=1 with hit=0, and go to IDLE.
REQ-040 mem_req SHALL be 0 in IDLE, LOOKUP and RESPOND.
REQ-041 mem_req SHALL never drop before mem_ready=1 except on reset.
REQ-042 read_data SHALL hold its last value when done=0.

Reset
REQ-043 reset=0 SHALL immediately force state IDLE and done=hit=busy=mem_req=mem_we=0; mem_addr, mem_wdata and read_data SHALL be 0.
REQ-044 reset=0 SHALL clear all valid/dirty bits and set age[way]=way in every set; data/tag contents are don't-care.
REQ-045 A reset mid-WRITEBACK, FILL or FLUSH SHALL abort the transaction with no done pulse; dirty data is lost.

Verification (defaults; memory model mem[a]=a, mem_ready after 3 cycles)
REQ-046 Read 1 after reset -> FILL with mem_addr=1, done/hit=0, read_data=1; read 1 again -> done 2 edges after acceptance, hit=1, read_data=1, no mem_req.
REQ-047 Read 20, read 22, read 20 (hit), read 4 -> line 22 evicted (clean, no mem_we); read 20 -> hit=1; read 22 -> miss.
REQ-048 Write 0xABCD to 2, read 4, read 6 -> WRITEBACK mem_we=1, mem_addr=2, mem_wdata=0xABCD, then FILL of 6; read 2 -> miss returning 0xABCD from the model.
REQ-049 Dirty lines 2 and 3, flush -> write-backs to 2 then 3 in scan order, then done; read 2 -> miss.
REQ-050 reset=0 while FILL has mem_req=1 -> mem_req=0 in the same cycle, no done; after release, read of the same address misses.
REQ-051 read=write=1, address 5 -> treated as a store; read pulse while busy -> ignored, no second done.
